// File: rtl/arcade_input_mapper.sv
// Player-input front end: merges PS/2 keys with HPS joystick words into per-player
// control vectors, with screen rotation, button-0 autofire and timed coin pulses.
module arcade_input_mapper #(
    parameter int BUTTONS      = 3,
    parameter int COIN_PULSE   = 120000,
    parameter int COIN_GAP     = 240000,
    parameter int AUTOFIRE_DIV = 600000
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [10:0]        ps2_key,
    input  logic [15:0]        joystick_0,
    input  logic [15:0]        joystick_1,
    input  logic [1:0]         rotate,
    input  logic               autofire_en,
    input  logic               coin_from_start,
    output logic [BUTTONS+5:0] p1_ctl,
    output logic [BUTTONS+5:0] p2_ctl
);
    localparam int W         = BUTTONS + 6;
    localparam int START_BIT = BUTTONS + 4;
    localparam int COIN_BIT  = BUTTONS + 5;
    localparam int CMAX      = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
    localparam int CW        = $clog2(CMAX + 1);
    localparam int AW        = $clog2(AUTOFIRE_DIV + 1);

    localparam logic [CW-1:0] PULSE_LOAD = CW'(COIN_PULSE - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(COIN_GAP - 1);
    localparam logic [AW-1:0] AF_LAST    = AW'(AUTOFIRE_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam int K_R = 0, K_L = 1, K_D = 2, K_U = 3, K_SPACE = 4, K_CTRL = 5;
    localparam int K_B1 = 6, K_B2 = 7, K_START1 = 8, K_COIN1 = 9, K_START2 = 10, K_COIN2 = 11;

    logic [11:0]       key_r;
    logic [11:0]       key_hit_s;
    logic              old_tog_r;
    logic [W-1:0]      kb_p1_s;
    logic [W-1:0]      kb_p2_s;
    logic [1:0][W-1:0] raw_s;
    logic [AW-1:0]     af_cnt_r;
    logic              af_phase_r;
    logic              gate0_s;
    logic [1:0]        coin_on_s;

    // Rotation acts on directions only; button 0 is gated and coin comes from the pulse FSM.
    function automatic logic [W-1:0] shape_ctl(input logic [W-1:0] raw, input logic [1:0] rot,
                                               input logic gate0, input logic coin);
        logic [W-1:0] ctl;
        ctl = raw;
        case (rot)
            2'd1:    ctl[3:0] = {raw[1], raw[0], raw[2], raw[3]};
            2'd2:    ctl[3:0] = {raw[2], raw[3], raw[0], raw[1]};
            2'd3:    ctl[3:0] = {raw[0], raw[1], raw[3], raw[2]};
            default: ctl[3:0] = raw[3:0];
        endcase
        ctl[4]        = raw[4] & gate0;
        ctl[COIN_BIT] = coin;
        return ctl;
    endfunction

    // Scan-code match; arrows ignore the E0 prefix bit.
    always_comb begin
        key_hit_s           = 12'd0;
        key_hit_s[K_R]      = (ps2_key[7:0] == 8'h74);
        key_hit_s[K_L]      = (ps2_key[7:0] == 8'h6B);
        key_hit_s[K_D]      = (ps2_key[7:0] == 8'h72);
        key_hit_s[K_U]      = (ps2_key[7:0] == 8'h75);
        key_hit_s[K_SPACE]  = (ps2_key[8:0] == 9'h029);
        key_hit_s[K_CTRL]   = (ps2_key[8:0] == 9'h014);
        key_hit_s[K_B1]     = (ps2_key[8:0] == 9'h011);
        key_hit_s[K_B2]     = (BUTTONS >= 32'd3) && (ps2_key[8:0] == 9'h012);
        key_hit_s[K_START1] = (ps2_key[8:0] == 9'h005);
        key_hit_s[K_COIN1]  = (ps2_key[8:0] == 9'h02E);
        key_hit_s[K_START2] = (ps2_key[8:0] == 9'h006);
        key_hit_s[K_COIN2]  = (ps2_key[8:0] == 9'h036);
    end

    // Key state registers; old_tog tracks the toggle even through reset.
    always_ff @(posedge clk_sys) begin
        old_tog_r <= ps2_key[10];
        if (reset) begin
            key_r <= 12'd0;
        end else if (ps2_key[10] != old_tog_r) begin
            key_r <= (key_r & ~key_hit_s) | ({12{ps2_key[9]}} & key_hit_s);
        end else begin
            key_r <= key_r;
        end
    end

    // Keyboard contribution per player; start/coin are written last so small BUTTONS wins.
    always_comb begin
        kb_p1_s            = '0;
        kb_p1_s[0]         = key_r[K_R];
        kb_p1_s[1]         = key_r[K_L];
        kb_p1_s[2]         = key_r[K_D];
        kb_p1_s[3]         = key_r[K_U];
        kb_p1_s[4]         = key_r[K_SPACE] | key_r[K_CTRL];
        kb_p1_s[5]         = (BUTTONS >= 32'd2) ? key_r[K_B1] : 1'b0;
        kb_p1_s[6]         = (BUTTONS >= 32'd3) ? key_r[K_B2] : 1'b0;
        kb_p1_s[START_BIT] = key_r[K_START1];
        kb_p1_s[COIN_BIT]  = key_r[K_COIN1];
        kb_p2_s            = '0;
        kb_p2_s[START_BIT] = key_r[K_START2];
        kb_p2_s[COIN_BIT]  = key_r[K_COIN2];
        raw_s[0]           = joystick_0[W-1:0] | kb_p1_s;
        raw_s[1]           = joystick_1[W-1:0] | kb_p2_s;
        gate0_s            = ~autofire_en | af_phase_r;
    end

    // Free-running autofire divider.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            af_cnt_r   <= '0;
            af_phase_r <= 1'b1;
        end else if (af_cnt_r == AF_LAST) begin
            af_cnt_r   <= '0;
            af_phase_r <= ~af_phase_r;
        end else begin
            af_cnt_r   <= af_cnt_r + AW'(1);
        end
    end

    genvar p;
    generate
        for (p = 0; p < 2; p++) begin : g_coin
            logic [1:0]    state_r;
            logic [CW-1:0] cnt_r;
            logic          pend_r;
            logic          coin_prev_r;
            logic          start_prev_r;
            logic          trig_s;

            assign trig_s = (raw_s[p][COIN_BIT] & ~coin_prev_r)
                          | (coin_from_start & raw_s[p][START_BIT] & ~start_prev_r);
            assign coin_on_s[p] = (state_r == ST_PULSE);

            // Coin pulse/gap sequencer with a single pending-coin slot.
            always_ff @(posedge clk_sys) begin
                coin_prev_r  <= raw_s[p][COIN_BIT];
                start_prev_r <= raw_s[p][START_BIT];
                if (reset) begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    pend_r  <= 1'b0;
                end else begin
                    case (state_r)
                        ST_IDLE: begin
                            if (trig_s) begin
                                state_r <= ST_PULSE;
                                cnt_r   <= PULSE_LOAD;
                            end
                        end
                        ST_PULSE: begin
                            if (trig_s) pend_r <= 1'b1;
                            if (cnt_r == '0) begin
                                state_r <= ST_GAP;
                                cnt_r   <= GAP_LOAD;
                            end else begin
                                cnt_r   <= cnt_r - CW'(1);
                            end
                        end
                        ST_GAP: begin
                            if (cnt_r != '0) begin
                                cnt_r <= cnt_r - CW'(1);
                                if (trig_s) pend_r <= 1'b1;
                            end else if (pend_r | trig_s) begin
                                // A pending coin is consumed; a coincident trigger then becomes the new pending one.
                                state_r <= ST_PULSE;
                                cnt_r   <= PULSE_LOAD;
                                pend_r  <= pend_r & trig_s;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end
                        default: begin
                            state_r <= ST_IDLE;
                            cnt_r   <= '0;
                            pend_r  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // Registered player outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            p1_ctl <= '0;
            p2_ctl <= '0;
        end else begin
            p1_ctl <= shape_ctl(raw_s[0], rotate, gate0_s, coin_on_s[0]);
            p2_ctl <= shape_ctl(raw_s[1], rotate, gate0_s, coin_on_s[1]);
        end
    end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench for arcade_input_mapper with short coin and autofire timings.
module tb_arcade_input_mapper;
    localparam int W = 9;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic [10:0]   ps2_key = 11'd0;
    logic [15:0]   joystick_0 = 16'd0;
    logic [15:0]   joystick_1 = 16'd0;
    logic [1:0]    rotate = 2'd0;
    logic          autofire_en = 1'b0;
    logic          coin_from_start = 1'b0;
    logic [W-1:0]  p1_ctl;
    logic [W-1:0]  p2_ctl;
    logic          tog = 1'b0;

    int vectors = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [W-1:0] exp;
        logic [W-1:0] mask;
        bit           p2;
    } exp_t;
    exp_t sb[$];

    arcade_input_mapper #(
        .BUTTONS(3), .COIN_PULSE(4), .COIN_GAP(3), .AUTOFIRE_DIV(5)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1), .rotate(rotate),
        .autofire_en(autofire_en), .coin_from_start(coin_from_start),
        .p1_ctl(p1_ctl), .p2_ctl(p2_ctl)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic ps2_event(input logic pressed, input logic [8:0] code);
        tog = ~tog;
        ps2_key = {tog, pressed, code};
    endtask

    task automatic test_reset();
        exp_t e;
        logic [W-1:0] obs;
        reset = 1'b1;
        joystick_0 = 16'h000F;
        tog = 1'b1;
        ps2_key = {1'b1, 1'b1, 9'h029};
        step(3);
        vectors++;
        if (p1_ctl !== 9'h000) begin errors++; $display("FAIL rst_p1: got %h, need 000", p1_ctl); end
        vectors++;
        if (p2_ctl !== 9'h000) begin errors++; $display("FAIL rst_p2: got %h, need 000", p2_ctl); end
        reset = 1'b0;
        sb.push_back('{"rst_joy_pass", 9'h00F, 9'h0FF, 1'b0});
        step(1);
        e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
        if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s: got %h, need %h", e.name, obs & e.mask, e.exp); end
        sb.push_back('{"rst_no_spurious_key", 9'h000, 9'h010, 1'b0});
        step(2);
        e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
        if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s: got %h, need %h", e.name, obs & e.mask, e.exp); end
        joystick_0 = 16'd0;
        step(1);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [W-1:0] obs;
        logic [W-1:0] pats [8] = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020, 9'h040, 9'h080};
        for (int i = 0; i < 8; i++) begin
            joystick_0 = {7'd0, pats[i]};
            joystick_1 = {7'd0, ~pats[i] & 9'h0FF};
            sb.push_back('{"b2b_p1", pats[i], 9'h0FF, 1'b0});
            sb.push_back('{"b2b_p2", ~pats[i] & 9'h0FF, 9'h0FF, 1'b1});
            step(1);
            for (int k = 0; k < 2; k++) begin
                e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
                if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s[%0d]: got %h, need %h", e.name, i, obs & e.mask, e.exp); end
            end
        end
        joystick_0 = 16'd0;
        joystick_1 = 16'd0;
        step(2);
    endtask

    task automatic test_keyboard();
        exp_t e;
        logic [W-1:0] obs;
        ps2_event(1'b1, 9'h175);
        sb.push_back('{"kbd_latency1", 9'h000, 9'h008, 1'b0});
        step(1);
        e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
        if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s: got %h, need %h", e.name, obs & e.mask, e.exp); end
        sb.push_back('{"kbd_up_press", 9'h008, 9'h008, 1'b0});
        step(1);
        e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
        if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s: got %h, need %h", e.name, obs & e.mask, e.exp); end
        ps2_key = {tog, 1'b0, 9'h175};
        sb.push_back('{"kbd_same_toggle", 9'h008, 9'h008, 1'b0});
        step(2);
        e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
        if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s: got %h, need %h", e.name, obs & e.mask, e.exp); end
        ps2_event(1'b0, 9'h175);
        sb.push_back('{"kbd_up_release", 9'h000, 9'h008, 1'b0});
        step(2);
        e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
        if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s: got %h, need %h", e.name, obs & e.mask, e.exp); end
        ps2_event(1'b1, 9'h075);
        sb.push_back('{"kbd_up_no_e0", 9'h008, 9'h008, 1'b0});
        step(2);
        e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
        if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s: got %h, need %h", e.name, obs & e.mask, e.exp); end
        ps2_event(1'b0, 9'h175);
        step(1);
        ps2_event(1'b1, 9'h011);
        step(1);
        ps2_event(1'b1, 9'h012);
        step(1);
        ps2_event(1'b1, 9'h0AA);
        sb.push_back('{"kbd_b1_b2_unmatched", 9'h060, 9'h1FF, 1'b0});
        step(2);
        e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
        if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s: got %h, need %h", e.name, obs & e.mask, e.exp); end
        ps2_event(1'b0, 9'h011);
        step(1);
        ps2_event(1'b0, 9'h012);
        step(3);
    endtask

    task automatic test_rotation();
        exp_t e;
        logic [W-1:0] obs;
        logic [W-1:0] exp_dir [4] = '{9'h002, 9'h008, 9'h001, 9'h004};
        joystick_0 = 16'h0002;
        for (int r = 0; r < 4; r++) begin
            rotate = 2'(r);
            sb.push_back('{"rotate_left", exp_dir[r], 9'h00F, 1'b0});
            step(1);
            e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
            if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s rot=%0d: got %h, need %h", e.name, r, obs & e.mask, e.exp); end
        end
        rotate = 2'd0;
        joystick_0 = 16'd0;
        step(2);
    endtask

    task automatic test_coin_pulse();
        exp_t e;
        logic [W-1:0] obs;
        logic stim [20] = '{1,1,0,1,0,1,0,0,0,0, 0,0,0,0,0,0,0,0,0,0};
        logic expc [20] = '{0,1,1,1,1,0,0,0,1,1, 1,1,0,0,0,0,0,0,0,0};
        for (int j = 0; j < 20; j++) begin
            joystick_0 = stim[j] ? 16'h0100 : 16'h0000;
            sb.push_back('{"coin_pulse", expc[j] ? 9'h100 : 9'h000, 9'h100, 1'b0});
            step(1);
            e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
            if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s cycle %0d: got %h, need %h", e.name, j + 1, obs & e.mask, e.exp); end
        end
    endtask

    task automatic test_coin_from_start();
        exp_t e;
        logic [W-1:0] obs;
        logic [W-1:0] exp_on [7]  = '{9'h000, 9'h080, 9'h180, 9'h180, 9'h180, 9'h180, 9'h080};
        logic [W-1:0] exp_off [6] = '{9'h000, 9'h080, 9'h080, 9'h080, 9'h080, 9'h080};
        coin_from_start = 1'b1;
        ps2_event(1'b1, 9'h006);
        for (int j = 0; j < 7; j++) begin
            sb.push_back('{"cfs_on_p2", exp_on[j], 9'h180, 1'b1});
            step(1);
            e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
            if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s cycle %0d: got %h, need %h", e.name, j + 1, obs & e.mask, e.exp); end
        end
        vectors++;
        if ((p1_ctl & 9'h180) !== 9'h000) begin errors++; $display("FAIL cfs_p1_quiet: got %h, need 000", p1_ctl & 9'h180); end
        ps2_event(1'b0, 9'h006);
        step(8);
        coin_from_start = 1'b0;
        ps2_event(1'b1, 9'h006);
        for (int j = 0; j < 6; j++) begin
            sb.push_back('{"cfs_off_p2", exp_off[j], 9'h180, 1'b1});
            step(1);
            e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
            if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s cycle %0d: got %h, need %h", e.name, j + 1, obs & e.mask, e.exp); end
        end
        ps2_event(1'b0, 9'h006);
        step(2);
    endtask

    task automatic test_autofire();
        exp_t e;
        logic [W-1:0] obs;
        logic prev_b0;
        int   last_t;
        int   ntrans;
        bit   b1_ok;
        ps2_event(1'b1, 9'h029);
        joystick_0 = 16'h0020;
        autofire_en = 1'b1;
        step(2);
        prev_b0 = p1_ctl[4];
        last_t = -1;
        ntrans = 0;
        b1_ok = 1'b1;
        for (int t = 0; t < 32; t++) begin
            step(1);
            if (p1_ctl[5] !== 1'b1) b1_ok = 1'b0;
            if (p1_ctl[4] !== prev_b0) begin
                if (last_t >= 0) begin
                    vectors++;
                    if (t - last_t !== 5) begin errors++; $display("FAIL af_period: got %0d, need 5", t - last_t); end
                end
                last_t = t;
                ntrans++;
            end
            prev_b0 = p1_ctl[4];
        end
        vectors++;
        if (ntrans < 5) begin errors++; $display("FAIL af_toggles: got %0d, need >=5", ntrans); end
        vectors++;
        if (!b1_ok) begin errors++; $display("FAIL af_b1_ungated: got 0, need 1"); end
        autofire_en = 1'b0;
        for (int j = 0; j < 8; j++) begin
            sb.push_back('{"af_off_steady", 9'h030, 9'h030, 1'b0});
            step(1);
            e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
            if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s cycle %0d: got %h, need %h", e.name, j, obs & e.mask, e.exp); end
        end
        ps2_event(1'b0, 9'h029);
        joystick_0 = 16'd0;
        step(2);
    endtask

    task automatic test_reset_mid_pulse();
        exp_t e;
        logic [W-1:0] obs;
        logic expc [5] = '{1, 1, 1, 1, 0};
        joystick_0 = 16'h0100;
        sb.push_back('{"rmp_pulse_on", 9'h100, 9'h100, 1'b0});
        step(2);
        e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
        if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s: got %h, need %h", e.name, obs & e.mask, e.exp); end
        reset = 1'b1;
        sb.push_back('{"rmp_reset_low", 9'h000, 9'h100, 1'b0});
        step(1);
        e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
        if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s: got %h, need %h", e.name, obs & e.mask, e.exp); end
        reset = 1'b0;
        for (int j = 0; j < 6; j++) begin
            sb.push_back('{"rmp_held_no_pulse", 9'h000, 9'h100, 1'b0});
            step(1);
            e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
            if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s cycle %0d: got %h, need %h", e.name, j, obs & e.mask, e.exp); end
        end
        joystick_0 = 16'd0;
        step(1);
        joystick_0 = 16'h0100;
        sb.push_back('{"rmp_retrigger_lat", 9'h000, 9'h100, 1'b0});
        step(1);
        e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
        if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s: got %h, need %h", e.name, obs & e.mask, e.exp); end
        for (int j = 0; j < 5; j++) begin
            sb.push_back('{"rmp_retrigger", expc[j] ? 9'h100 : 9'h000, 9'h100, 1'b0});
            step(1);
            e = sb.pop_front(); obs = e.p2 ? p2_ctl : p1_ctl; vectors++;
            if ((obs & e.mask) !== e.exp) begin errors++; $display("FAIL %s cycle %0d: got %h, need %h", e.name, j, obs & e.mask, e.exp); end
        end
        joystick_0 = 16'd0;
        step(6);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_keyboard();
        test_rotation();
        test_coin_pulse();
        test_coin_from_start();
        test_autofire();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Parametrised player-input front end for arcade cores: merges PS/2 keyboard events and per-player HPS joystick words into per-player control vectors with selectable screen rotation (0/90/180/270), optional autofire on button 0, and a timed coin-pulse generator. It sits between `hps_io` and the game core, and replaces ad-hoc per-core keyboard decoding and button ORing. All outputs are registered, in the `clk_sys` domain.

## Interface
Parameters:
- BUTTONS, 3 — fire buttons per player (1..8).
- COIN_PULSE, 120000 — coin-high length in clk_sys cycles (≥1).
- COIN_GAP, 240000 — forced coin-low interval after each pulse (≥1).
- AUTOFIRE_DIV, 600000 — autofire half-period in cycles (≥1).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ps2_key  in  11  [10] toggle-per-event, [9] pressed, [8:0] code ([8] = E0 extended).
- joystick_0, joystick_1  in  16  [0]R [1]L [2]D [3]U [4+k] button k, [4+BUTTONS] start, [5+BUTTONS] coin.
- rotate  in  2  0 none, 1 = 90°, 2 = 180°, 3 = 270°.
- autofire_en  in  1  gate button 0 with autofire phase.
- coin_from_start  in  1  a start rising edge also triggers that player's coin pulse.
- p1_ctl, p2_ctl  out  BUTTONS+6  same bit layout as the joystick low bits: R, L, D, U, buttons, start, coin.

## Operation
- Keyboard events: the block keeps a copy `old_tog` of ps2_key[10]. When ps2_key[10] ≠ old_tog, the event is valid and the matched key register is set to ps2_key[9]. Unmatched codes are ignored.
- Key map, player 1: arrows U/D/L/R = X75/X72/X6B/X74 (bit 8 ignored); button0 = 029 or 014; button1 = 011; button2 = 012 (only when BUTTONS ≥ 3); start1 = 005 (F1); coin1 = 02E ('5').
- Key map, player 2: start2 = 006 (F2); coin2 = 036 ('6').
- Merge: raw_pN = joystick_(N-1)[BUTTONS+5:0] OR the keyboard bits for player N.
- Rotation, applied to directions only; output ← source:
  - rotate 0: identity.
  - rotate 1: U←L, D←R, L←D, R←U.
  - rotate 2: U←D, D←U, L←R, R←L.
  - rotate 3: U←R, D←L, L←U, R←D.
- Autofire:
  - A free-running counter runs 0..AUTOFIRE_DIV-1; `af_phase` toggles at each wrap.
  - When autofire_en=1, button0 out = raw button0 AND af_phase. Other buttons are never gated.
- Coin FSM, one per player, states IDLE, PULSE, GAP:
  - Trigger = rising edge of the raw coin bit, or (coin_from_start AND rising edge of raw start).
  - IDLE + trigger → PULSE, counter loaded with COIN_PULSE-1, coin out = 1.
  - PULSE at counter 0 → GAP, counter loaded with COIN_GAP-1, coin out = 0.
  - GAP at counter 0 → IDLE, or straight to PULSE if `pend` is set; `pend` is then cleared.
  - A trigger during PULSE or GAP sets `pend`. `pend` saturates at one; further triggers are dropped.
  - A trigger and a GAP expiry in the same cycle count as one coin: go to PULSE, `pend` stays 0.
- Start bits pass through unaltered; coin_from_start does not delay start.
- Counter widths are $clog2(max value + 1), with no wrap beyond the terminal count.

## Timing
- Reset values:
  - p1_ctl, p2_ctl = 0; all key registers = 0.
  - Coin FSMs = IDLE; pend = 0; counters = 0; af_phase = 1.
  - During reset, old_tog ← ps2_key[10], so the first cycle after reset produces no spurious event.
  - Edge-detect registers ← current raw bits during reset, so an input held through reset does not trigger a coin.
- Reset asserted mid-pulse: coin out is 0 on the next edge and the FSM returns to IDLE.
- Latency: a joystick change appears at the output 1 cycle later. A PS/2 event appears 2 cycles later (key register, then output register).
- Coin: trigger sampled at edge t → coin out high on edges t+1 .. t+COIN_PULSE, low for the next COIN_GAP cycles minimum.
- A rotate or autofire_en change takes effect on the next output register update, with no glitch filtering.

## Test plan
- Keyboard: toggle ps2_key with {1,1,E075} → p1 U = 1 two cycles later. Then {0,0,E075} → U = 0. A repeated event with an unchanged toggle bit is ignored.
- Rotation: joystick_0 = 0x0002 (L) with rotate = 0, 1, 2, 3 → p1 direction bits = L, U, R, D respectively.
- Coin pulse (COIN_PULSE=4, COIN_GAP=3): one coin edge → coin high exactly 4 cycles, then low ≥3 cycles. A second edge during PULSE → a second 4-cycle pulse starting right after the gap. A third edge in the same window → dropped.
- coin_from_start: coin_from_start = 1 and F2 pressed → p2 start = 1 and p2 coin pulses. With coin_from_start = 0 → start only.
- Autofire (AUTOFIRE_DIV=5): space held, autofire_en = 1 → button0 toggles every 5 cycles. With autofire_en = 0 → steady 1. Button1 is never gated.
- Reset: assert reset for 1 cycle mid-PULSE with coin still held → coin = 0 and FSM IDLE, and no new pulse until the coin input falls and rises again.
